// File: rtl/rf_ldst_sched.sv
// -----------------------------------------------------------------------------
// rf_ldst_sched
//
// Command scheduler in front of the rf_ldst transfer engine. Load/store
// commands from the decoder are queued in a small FIFO and issued one at a
// time: the head is popped into the operand registers and a one-cycle start
// strobe is sent. The scheduler then waits for a fresh rising edge on
// ldst_done and presents a tagged completion until the caller consumes it.
// Commands with line_num==0 complete immediately without a start strobe.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid && ready are both high. The producer keeps valid and its payload
// stable until that edge; ready may change freely and a ready seen while
// valid is low has no effect.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command input handshake (ready = queue not full)
//   cmd_is_store         1 = store RF->SDRAM, 0 = load SDRAM->RF
//   cmd_rf_addr          RF start line
//   cmd_sdram_addr       SDRAM start byte address
//   cmd_line_num         number of lines to move
//   cmd_tag              caller tag returned with the completion
//   ldst_load_start      one-cycle load start to rf_ldst
//   ldst_store_start     one-cycle store start to rf_ldst
//   ldst_rf_addr/ldst_sdram_addr/ldst_line_num  operands, stable from the
//                        start strobe until the next pop
//   ldst_done            transfer done from rf_ldst (level or pulse)
//   cpl_valid/cpl_ready  completion output handshake
//   cpl_tag, cpl_is_store  tag and type of the completed command
//   busy                 FSM not idle or queue non-empty
//   pending              number of queued (not yet popped) commands
// -----------------------------------------------------------------------------
module rf_ldst_sched #(
  parameter int RF_ADDR_W    = 10,
  parameter int LINE_NUM_W   = 11,
  parameter int SDRAM_ADDR_W = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int TAG_W        = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_is_store,
  input  logic [RF_ADDR_W-1:0]              cmd_rf_addr,
  input  logic [SDRAM_ADDR_W-1:0]           cmd_sdram_addr,
  input  logic [LINE_NUM_W-1:0]             cmd_line_num,
  input  logic [TAG_W-1:0]                  cmd_tag,
  output logic                              ldst_load_start,
  output logic                              ldst_store_start,
  output logic [RF_ADDR_W-1:0]              ldst_rf_addr,
  output logic [SDRAM_ADDR_W-1:0]           ldst_sdram_addr,
  output logic [LINE_NUM_W-1:0]             ldst_line_num,
  input  logic                              ldst_done,
  output logic                              cpl_valid,
  input  logic                              cpl_ready,
  output logic [TAG_W-1:0]                  cpl_tag,
  output logic                              cpl_is_store,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending
);

  localparam int PEND_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam logic [PEND_W-1:0] FULL_CNT = PEND_W'(FIFO_DEPTH);

  typedef struct packed {
    logic                    is_store;
    logic [RF_ADDR_W-1:0]    rf_addr;
    logic [SDRAM_ADDR_W-1:0] sdram_addr;
    logic [LINE_NUM_W-1:0]   line_num;
    logic [TAG_W-1:0]        tag;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    CPL   = 2'd3
  } state_t;

  // Queue storage carries no reset: entries are only read when count_q says
  // they were written.
  cmd_t fifo_mem [FIFO_DEPTH];

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0]       count_q, count_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    load_start_q, load_start_d;
  logic                    store_start_q, store_start_d;
  logic [RF_ADDR_W-1:0]    rf_addr_q, rf_addr_d;
  logic [SDRAM_ADDR_W-1:0] sdram_addr_q, sdram_addr_d;
  logic [LINE_NUM_W-1:0]   line_num_q, line_num_d;
  logic [TAG_W-1:0]        cur_tag_q, cur_tag_d;
  logic                    cur_store_q, cur_store_d;
  logic                    cpl_valid_q, cpl_valid_d;
  logic [TAG_W-1:0]        cpl_tag_q, cpl_tag_d;
  logic                    cpl_is_store_q, cpl_is_store_d;
  logic                    busy_q, busy_d;
  logic                    done_q;

  logic push;
  logic pop;
  logic done_rise;
  cmd_t cmd_in;
  cmd_t head;

  always_comb begin
    cmd_in.is_store   = cmd_is_store;
    cmd_in.rf_addr    = cmd_rf_addr;
    cmd_in.sdram_addr = cmd_sdram_addr;
    cmd_in.line_num   = cmd_line_num;
    cmd_in.tag        = cmd_tag;
  end

  always_comb begin
    push      = cmd_valid && cmd_ready_q;
    pop       = (state_q == IDLE) && (count_q != '0);
    head      = fifo_mem[rd_ptr_q];
    // Only a fresh rising edge counts, so a done left high from an earlier
    // transfer cannot complete the current one.
    done_rise = ldst_done && !done_q;

    state_d        = state_q;
    load_start_d   = 1'b0;
    store_start_d  = 1'b0;
    rf_addr_d      = rf_addr_q;
    sdram_addr_d   = sdram_addr_q;
    line_num_d     = line_num_q;
    cur_tag_d      = cur_tag_q;
    cur_store_d    = cur_store_q;
    cpl_valid_d    = cpl_valid_q;
    cpl_tag_d      = cpl_tag_q;
    cpl_is_store_d = cpl_is_store_q;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          rf_addr_d    = head.rf_addr;
          sdram_addr_d = head.sdram_addr;
          line_num_d   = head.line_num;
          cur_tag_d    = head.tag;
          cur_store_d  = head.is_store;
          if (head.line_num == '0) begin
            // Nothing to move: complete directly without touching rf_ldst.
            state_d        = CPL;
            cpl_valid_d    = 1'b1;
            cpl_tag_d      = head.tag;
            cpl_is_store_d = head.is_store;
          end else begin
            state_d       = ISSUE;
            load_start_d  = !head.is_store;
            store_start_d = head.is_store;
          end
        end
      end
      ISSUE: begin
        // A done edge during the strobe cycle belongs to nothing we issued.
        state_d = WAIT;
      end
      WAIT: begin
        if (done_rise) begin
          state_d        = CPL;
          cpl_valid_d    = 1'b1;
          cpl_tag_d      = cur_tag_q;
          cpl_is_store_d = cur_store_q;
        end
      end
      CPL: begin
        if (cpl_ready) begin
          state_d     = IDLE;
          cpl_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    count_d     = count_q + PEND_W'(push) - PEND_W'(pop);
    cmd_ready_d = (count_d != FULL_CNT);
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= cmd_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      cmd_ready_q    <= 1'b1;
      load_start_q   <= 1'b0;
      store_start_q  <= 1'b0;
      rf_addr_q      <= '0;
      sdram_addr_q   <= '0;
      line_num_q     <= '0;
      cur_tag_q      <= '0;
      cur_store_q    <= 1'b0;
      cpl_valid_q    <= 1'b0;
      cpl_tag_q      <= '0;
      cpl_is_store_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b1;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      cmd_ready_q    <= cmd_ready_d;
      load_start_q   <= load_start_d;
      store_start_q  <= store_start_d;
      rf_addr_q      <= rf_addr_d;
      sdram_addr_q   <= sdram_addr_d;
      line_num_q     <= line_num_d;
      cur_tag_q      <= cur_tag_d;
      cur_store_q    <= cur_store_d;
      cpl_valid_q    <= cpl_valid_d;
      cpl_tag_q      <= cpl_tag_d;
      cpl_is_store_q <= cpl_is_store_d;
      busy_q         <= busy_d;
      done_q         <= ldst_done;
    end
  end

  assign cmd_ready        = cmd_ready_q;
  assign ldst_load_start  = load_start_q;
  assign ldst_store_start = store_start_q;
  assign ldst_rf_addr     = rf_addr_q;
  assign ldst_sdram_addr  = sdram_addr_q;
  assign ldst_line_num    = line_num_q;
  assign cpl_valid        = cpl_valid_q;
  assign cpl_tag          = cpl_tag_q;
  assign cpl_is_store     = cpl_is_store_q;
  assign busy             = busy_q;
  assign pending          = count_q;

endmodule

// File: tb/tb_rf_ldst_sched.sv
// -----------------------------------------------------------------------------
// tb_rf_ldst_sched
//
// Self-checking bench for rf_ldst_sched: reset values, a table of single
// commands with expected strobe type and completion latency, hand-written
// multi-cycle sequences (back-to-back, full queue, stale done, reset in
// flight) and a randomized run against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_rf_ldst_sched;

  localparam int RA_W  = 10;
  localparam int LN_W  = 11;
  localparam int SA_W  = 32;
  localparam int DEPTH = 4;
  localparam int TG_W  = 4;
  localparam int PD_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_is_store;
  logic [RA_W-1:0]   cmd_rf_addr;
  logic [SA_W-1:0]   cmd_sdram_addr;
  logic [LN_W-1:0]   cmd_line_num;
  logic [TG_W-1:0]   cmd_tag;
  logic              ldst_load_start;
  logic              ldst_store_start;
  logic [RA_W-1:0]   ldst_rf_addr;
  logic [SA_W-1:0]   ldst_sdram_addr;
  logic [LN_W-1:0]   ldst_line_num;
  logic              ldst_done;
  logic              cpl_valid;
  logic              cpl_ready;
  logic [TG_W-1:0]   cpl_tag;
  logic              cpl_is_store;
  logic              busy;
  logic [PD_W-1:0]   pending;

  rf_ldst_sched #(
    .RF_ADDR_W(RA_W), .LINE_NUM_W(LN_W), .SDRAM_ADDR_W(SA_W),
    .FIFO_DEPTH(DEPTH), .TAG_W(TG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_is_store(cmd_is_store), .cmd_rf_addr(cmd_rf_addr),
    .cmd_sdram_addr(cmd_sdram_addr), .cmd_line_num(cmd_line_num),
    .cmd_tag(cmd_tag),
    .ldst_load_start(ldst_load_start), .ldst_store_start(ldst_store_start),
    .ldst_rf_addr(ldst_rf_addr), .ldst_sdram_addr(ldst_sdram_addr),
    .ldst_line_num(ldst_line_num), .ldst_done(ldst_done),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
    .cpl_is_store(cpl_is_store), .busy(busy), .pending(pending)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_load_start"}, ldst_load_start, 0);
    chk({tag, "_store_start"}, ldst_store_start, 0);
    chk({tag, "_rf_addr"}, ldst_rf_addr, 0);
    chk({tag, "_sdram_addr"}, ldst_sdram_addr, 0);
    chk({tag, "_line_num"}, ldst_line_num, 0);
    chk({tag, "_cpl_valid"}, cpl_valid, 0);
    chk({tag, "_cpl_tag"}, cpl_tag, 0);
    chk({tag, "_cpl_is_store"}, cpl_is_store, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pending"}, pending, 0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_cmd(input logic st, input logic [RA_W-1:0] rf,
                           input logic [SA_W-1:0] sa, input logic [LN_W-1:0] ln,
                           input logic [TG_W-1:0] tg);
    cmd_is_store   = st;
    cmd_rf_addr    = rf;
    cmd_sdram_addr = sa;
    cmd_line_num   = ln;
    cmd_tag        = tg;
    cmd_valid      = 1'b1;
  endtask

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds every accepted command, in acceptance order, until its
  // completion is consumed. front_popped tells whether the head has left the
  // DUT queue (start seen, or zero-length completion seen).
  typedef struct packed {
    logic            is_store;
    logic [RA_W-1:0] rf;
    logic [SA_W-1:0] sa;
    logic [LN_W-1:0] ln;
    logic [TG_W-1:0] tag;
  } mcmd_t;

  mcmd_t exp_q[$];
  bit    front_popped = 0;
  int    done_wait = 0;
  int    done_hold = 0;
  int    dly_min = 1;
  int    dly_max = 6;
  bit    last_acc = 0;
  int    n_starts = 0;

  // One clock of the rf_ldst/completion-consumer agent plus model checks.
  task automatic tick();
    logic  acc;
    logic  hs;
    logic [TG_W-1:0] htag;
    logic  hst;
    mcmd_t cin;
    mcmd_t got;
    int    exp_pend;
    acc  = cmd_valid && cmd_ready;
    hs   = cpl_valid && cpl_ready;
    htag = cpl_tag;
    hst  = cpl_is_store;
    cin  = '{cmd_is_store, cmd_rf_addr, cmd_sdram_addr, cmd_line_num, cmd_tag};
    step();
    last_acc = acc;
    if (acc) exp_q.push_back(cin);
    if (hs) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL cpl_unexpected: got tag 0x%0h want none", htag);
      end else begin
        got = exp_q.pop_front();
        chk("cpl_tag_order", htag, got.tag);
        chk("cpl_type_order", hst, got.is_store);
        front_popped = 0;
      end
    end
    // rf_ldst stand-in: raise done a few cycles after a start, hold briefly.
    if (done_hold > 0) begin
      done_hold--;
      if (done_hold == 0) ldst_done = 1'b0;
    end
    if (done_wait > 0) begin
      done_wait--;
      if (done_wait == 0) begin
        ldst_done = 1'b1;
        done_hold = $urandom_range(1, 3);
      end
    end
    if (ldst_load_start || ldst_store_start) begin
      chk("strobe_exclusive", ldst_load_start && ldst_store_start, 0);
      if (exp_q.size() == 0 || front_popped) begin
        n_chk++; n_bad++;
        $display("FAIL start_unexpected: got start with %0d queued, head issued=%0d want no start",
                 exp_q.size(), front_popped);
      end else begin
        got = exp_q[0];
        chk("start_type", ldst_store_start, got.is_store);
        chk("start_rf", ldst_rf_addr, got.rf);
        chk("start_sdram", ldst_sdram_addr, got.sa);
        chk("start_lines", ldst_line_num, got.ln);
        front_popped = 1;
        n_starts++;
        done_wait = $urandom_range(dly_min, dly_max);
      end
    end
    if (cpl_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_bad++;
        $display("FAIL cpl_valid_unexpected: got 1 want 0");
      end else if (exp_q[0].ln == '0) begin
        front_popped = 1;
      end else begin
        chk("cpl_without_start", front_popped, 1);
      end
    end
    exp_pend = exp_q.size() - (front_popped ? 1 : 0);
    chk("model_pending", pending, exp_pend);
    chk("model_cmd_ready", cmd_ready, exp_pend != DEPTH);
  endtask

  task automatic offer(input logic st, input logic [RA_W-1:0] rf,
                       input logic [SA_W-1:0] sa, input logic [LN_W-1:0] ln,
                       input logic [TG_W-1:0] tg);
    int budget;
    drive_cmd(st, rf, sa, ln, tg);
    budget = 0;
    tick();
    while (!last_acc && budget < 300) begin
      tick();
      budget++;
    end
    if (!last_acc) begin
      n_chk++; n_bad++;
      $display("FAIL offer_timeout: got no accept for tag %0d want accept", tg);
    end
    cmd_valid = 1'b0;
  endtask

  // ---------------- table-driven single commands ----------------
  // exp_lat: cycles from the accept edge to the edge that raises cpl_valid.
  // dly: cycles between seeing the start strobe and driving done high.
  typedef struct {
    logic            st;
    logic [RA_W-1:0] rf;
    logic [SA_W-1:0] sa;
    logic [LN_W-1:0] ln;
    logic [TG_W-1:0] tag;
    int              dly;
    int              exp_loads;
    int              exp_stores;
    int              exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    int loads;
    int stores;
    int done_at;
    string nm;
    nm = $sformatf("vec%0d", idx);
    drive_cmd(v.st, v.rf, v.sa, v.ln, v.tag);
    chk({nm, "_ready"}, cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    lat = -1; loads = 0; stores = 0; done_at = -1;
    for (int k = 1; k <= 300; k++) begin
      step();
      if (ldst_load_start)  loads++;
      if (ldst_store_start) stores++;
      if ((ldst_load_start || ldst_store_start) && done_at < 0) done_at = k + v.dly;
      if (k == done_at)     ldst_done = 1'b1;
      if (k == done_at + 1) ldst_done = 1'b0;
      if (cpl_valid) begin
        lat = k;
        break;
      end
    end
    ldst_done = 1'b0;
    chk({nm, "_latency"}, lat, v.exp_lat);
    chk({nm, "_loads"}, loads, v.exp_loads);
    chk({nm, "_stores"}, stores, v.exp_stores);
    chk({nm, "_op_rf"}, ldst_rf_addr, v.rf);
    chk({nm, "_op_sdram"}, ldst_sdram_addr, v.sa);
    chk({nm, "_op_lines"}, ldst_line_num, v.ln);
    chk({nm, "_cpl_tag"}, cpl_tag, v.tag);
    chk({nm, "_cpl_type"}, cpl_is_store, v.st);
    chk({nm, "_busy_in_cpl"}, busy, 1);
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk({nm, "_cpl_cleared"}, cpl_valid, 0);
    chk({nm, "_busy_after"}, busy, 0);
    chk({nm, "_pending_after"}, pending, 0);
    step();
  endtask

  vec_t vecs[6];

  initial begin
    int sent;
    int budget;
    bit any_start;
    bit any_cpl;
    bit any_pend;
    bit any_busy;

    vecs[0] = '{1'b0, 10'd0,    32'h2000_0000, 11'd8,     4'd3, 40, 1, 0, 42};
    vecs[1] = '{1'b1, 10'h3ff,  32'hffff_fffc, 11'h7ff,   4'hf, 1,  0, 1, 3};
    vecs[2] = '{1'b0, 10'd5,    32'h0000_0010, 11'd0,     4'd7, 0,  0, 0, 1};
    vecs[3] = '{1'b1, 10'd0,    32'h2001_0000, 11'd8,     4'd2, 5,  0, 1, 7};
    vecs[4] = '{1'b1, 10'd17,   32'h1234_5678, 11'd0,     4'd0, 0,  0, 0, 1};
    vecs[5] = '{1'b0, 10'h200,  32'h8000_0000, 11'd1,     4'd9, 2,  1, 0, 4};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_is_store = 1'b0; cmd_rf_addr = '0;
    cmd_sdram_addr = '0; cmd_line_num = '0; cmd_tag = '0;
    ldst_done = 1'b0; cpl_ready = 1'b0;
    repeat (3) step();
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- table ----
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // ---- back-to-back load then store; completion held 10 cycles ----
    drive_cmd(1'b0, 10'd4, 32'h0000_0100, 11'd8, 4'd1);
    step();
    drive_cmd(1'b1, 10'd0, 32'h2001_0000, 11'd8, 4'd2);
    step();
    cmd_valid = 1'b0;
    chk("b2b_load_start", ldst_load_start, 1);
    chk("b2b_no_store_yet", ldst_store_start, 0);
    chk("b2b_pending", pending, 1);
    chk("b2b_op_rf", ldst_rf_addr, 4);
    step();
    ldst_done = 1'b1;
    step();
    ldst_done = 1'b0;
    chk("b2b_cpl1_valid", cpl_valid, 1);
    chk("b2b_cpl1_tag", cpl_tag, 1);
    chk("b2b_cpl1_type", cpl_is_store, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_cpl_valid", cpl_valid, 1);
      chk("hold_cpl_tag", cpl_tag, 1);
      chk("hold_no_start", ldst_store_start || ldst_load_start, 0);
      chk("hold_pending", pending, 1);
    end
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk("b2b_cpl1_cleared", cpl_valid, 0);
    chk("b2b_no_store_at_hs", ldst_store_start, 0);
    step();
    chk("b2b_store_start", ldst_store_start, 1);
    chk("b2b_store_no_load", ldst_load_start, 0);
    chk("b2b_store_sdram", ldst_sdram_addr, 32'h2001_0000);
    chk("b2b_store_lines", ldst_line_num, 8);
    chk("b2b_store_rf", ldst_rf_addr, 0);
    step();
    ldst_done = 1'b1;
    step();
    ldst_done = 1'b0;
    chk("b2b_cpl2_valid", cpl_valid, 1);
    chk("b2b_cpl2_tag", cpl_tag, 2);
    chk("b2b_cpl2_type", cpl_is_store, 1);
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk("b2b_busy_after", busy, 0);
    step();

    // ---- stale-high done must not complete the transfer ----
    ldst_done = 1'b1;
    step();
    step();
    drive_cmd(1'b0, 10'd1, 32'h0000_0040, 11'd4, 4'd5);
    step();
    cmd_valid = 1'b0;
    step();
    chk("stale_load_start", ldst_load_start, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_high_no_cpl", cpl_valid, 0);
    end
    ldst_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("stale_low_no_cpl", cpl_valid, 0);
    end
    ldst_done = 1'b1;
    step();
    ldst_done = 1'b0;
    chk("stale_fresh_cpl", cpl_valid, 1);
    chk("stale_fresh_tag", cpl_tag, 5);
    cpl_ready = 1'b1;
    step();
    cpl_ready = 1'b0;
    chk("stale_cpl_cleared", cpl_valid, 0);
    step();

    // ---- fill the queue while the first command waits ----
    exp_q.delete();
    front_popped = 0;
    n_starts = 0;
    dly_min = 20; dly_max = 20;
    cpl_ready = 1'b1;
    offer(1'b0, 10'd8, 32'h0000_1000, 11'd8, 4'd0);
    budget = 0;
    while (n_starts == 0 && budget < 20) begin
      tick();
      budget++;
    end
    chk("fill_first_started", n_starts, 1);
    for (int i = 1; i <= 4; i++)
      offer(i[0], 10'(i * 3), 32'(32'h3000_0000 + i * 64), (i == 3) ? 11'd0 : 11'(i), 4'(i));
    chk("fill_full_ready", cmd_ready, 0);
    chk("fill_full_pending", pending, 4);
    offer(1'b1, 10'd99, 32'h3000_0400, 11'd2, 4'd5);
    dly_min = 1; dly_max = 6;
    budget = 0;
    while (exp_q.size() != 0 && budget < 500) begin
      tick();
      budget++;
    end
    chk("fill_drained", exp_q.size(), 0);
    chk("fill_start_count", n_starts, 5);

    // ---- randomized run against the model ----
    sent = 0;
    budget = 0;
    cmd_valid = 1'b0;
    while ((sent < 40 || exp_q.size() != 0) && budget < 6000) begin
      if (!cmd_valid && sent < 40 && $urandom_range(0, 3) != 0) begin
        drive_cmd(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), $urandom,
                  ($urandom_range(0, 3) == 0) ? 11'd0 : 11'($urandom_range(1, 2047)),
                  4'($urandom_range(0, 15)));
      end
      tick();
      budget++;
      if (last_acc) begin
        sent++;
        cmd_valid = 1'b0;
      end
      cpl_ready = ($urandom_range(0, 99) < 60);
    end
    chk("rand_sent", sent, 40);
    chk("rand_drained", exp_q.size(), 0);
    cpl_ready = 1'b0;
    cmd_valid = 1'b0;
    repeat (4) step();
    ldst_done = 1'b0;
    step();

    // ---- reset during WAIT with two commands queued ----
    drive_cmd(1'b0, 10'd2, 32'h0000_2000, 11'd8, 4'd9);
    step();
    drive_cmd(1'b1, 10'd3, 32'h0000_3000, 11'd4, 4'd10);
    step();
    drive_cmd(1'b0, 10'd6, 32'h0000_6000, 11'd2, 4'd11);
    step();
    cmd_valid = 1'b0;
    step();
    chk("rstmid_pending", pending, 2);
    chk("rstmid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rstmid");
    step();
    @(negedge clk);
    rst_n = 1'b1;
    any_start = 0; any_cpl = 0; any_pend = 0; any_busy = 0;
    cpl_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ldst_done = (i == 5);
      step();
      if (ldst_load_start || ldst_store_start) any_start = 1;
      if (cpl_valid) any_cpl = 1;
      if (pending != 0) any_pend = 1;
      if (busy) any_busy = 1;
    end
    ldst_done = 1'b0;
    cpl_ready = 1'b0;
    chk("rstpost_no_start", any_start, 0);
    chk("rstpost_no_cpl", any_cpl, 0);
    chk("rstpost_pending", any_pend, 0);
    chk("rstpost_busy", any_busy, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
